// File: rtl/max7219_driver.sv
// Serial output stage for a MAX7219: replays the init ROM after reset or reinit,
// then shifts accepted 16-bit frames MSB-first on sck/din and latches each with a load rise.
module max7219_driver #(
    parameter int         CLK_DIV    = 1,
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7,
    parameter logic [7:0] DECODE     = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        reinit,
    output logic        init_done,
    output logic        max_sck,
    output logic        max_din,
    output logic        max_load
);

    typedef enum logic [2:0] {S_INIT, S_SHIFT, S_LATCH, S_GAP, S_IDLE} state_t;

    localparam int             DIV_W          = $clog2(2 * CLK_DIV + 1);
    localparam logic [DIV_W-1:0] BIT_LAST       = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF           = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_SHORT_LAST = DIV_W'((CLK_DIV >= 2) ? CLK_DIV - 2 : 0);
    localparam logic [2:0]       ROM_LEN        = 3'd5;

    state_t           state, state_n;
    logic [2:0]       rom_idx, rom_idx_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [15:0]      shreg, shreg_n;
    logic             init_done_n;
    logic             sck_n, din_n, load_n;
    logic             init_pending;

    function automatic logic [15:0] rom_frame(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_frame = 16'h0F00;
            3'd1:    rom_frame = {8'h0B, 5'b0, SCAN_LIMIT};
            3'd2:    rom_frame = {8'h09, DECODE};
            3'd3:    rom_frame = {8'h0A, 4'h0, INTENSITY};
            default: rom_frame = 16'h0C01;
        endcase
    endfunction

    // Between init frames the INIT cycle is taken out of GAP, so each frame costs 34*CLK_DIV.
    assign init_pending = !init_done && (rom_idx != ROM_LEN);
    assign frame_ready  = (state == S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        rom_idx_n   = rom_idx;
        bit_cnt_n   = bit_cnt;
        div_cnt_n   = div_cnt;
        shreg_n     = shreg;
        init_done_n = init_done;
        case (state)
            S_INIT: begin
                shreg_n   = rom_frame(rom_idx);
                rom_idx_n = rom_idx + 3'd1;
                bit_cnt_n = '0;
                div_cnt_n = '0;
                state_n   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt == BIT_LAST) begin
                    div_cnt_n = '0;
                    if (bit_cnt == 4'd15) begin
                        state_n = S_LATCH;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        shreg_n   = {shreg[14:0], 1'b0};
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (div_cnt == HALF_LAST) begin
                    div_cnt_n = '0;
                    state_n   = (init_pending && CLK_DIV == 1) ? S_INIT : S_GAP;
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (div_cnt == (init_pending ? GAP_SHORT_LAST : HALF_LAST)) begin
                    div_cnt_n = '0;
                    if (init_pending) begin
                        state_n = S_INIT;
                    end else begin
                        state_n     = S_IDLE;
                        init_done_n = 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            S_IDLE: begin
                if (reinit) begin
                    state_n     = S_INIT;
                    rom_idx_n   = '0;
                    init_done_n = 1'b0;
                end else if (frame_valid) begin
                    shreg_n   = frame_data;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                    state_n   = S_SHIFT;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    // NOTE: pin values are decoded from the next state and registered, so they line up
    // with the state they belong to while staying glitch-free and input-isolated.
    always_comb begin
        sck_n  = (state_n == S_SHIFT) && (div_cnt_n >= HALF);
        load_n = !((state_n == S_SHIFT) || (state_n == S_LATCH));
        din_n  = (state_n == S_SHIFT) ? shreg_n[15] : max_din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_idx   <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            shreg     <= '0;
            init_done <= 1'b0;
            max_sck   <= 1'b0;
            max_din   <= 1'b0;
            max_load  <= 1'b1;
        end else begin
            rom_idx   <= rom_idx_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            shreg     <= shreg_n;
            init_done <= init_done_n;
            max_sck   <= sck_n;
            max_din   <= din_n;
            max_load  <= load_n;
        end
    end

endmodule

// File: tb/tb_max7219_driver.sv
// Bench for max7219_driver: a MAX7219 pin model collects latched frames and is compared
// against frame lists built from the init ROM contents and the frames the bench sends.
module tb_max7219_driver;

    logic        clock;
    logic        reset, reset1;
    logic [15:0] frame_data, frame_data1;
    logic        frame_valid, frame_valid1;
    logic        reinit, reinit1;
    logic        frame_ready, init_done, max_sck, max_din, max_load;
    logic        frame_ready1, init_done1, max_sck1, max_din1, max_load1;

    int n_vec = 0;
    int n_err = 0;

    max7219_driver #(.CLK_DIV(2)) dut (
        .clock(clock), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .reinit(reinit), .init_done(init_done),
        .max_sck(max_sck), .max_din(max_din), .max_load(max_load)
    );

    max7219_driver #(.CLK_DIV(1)) dut1 (
        .clock(clock), .reset(reset1), .frame_data(frame_data1), .frame_valid(frame_valid1),
        .frame_ready(frame_ready1), .reinit(reinit1), .init_done(init_done1),
        .max_sck(max_sck1), .max_din(max_din1), .max_load(max_load1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MAX7219 pin models: DIN sampled on CLK rise, shift register latched on LOAD rise.
    logic [15:0] max_shift = '0, max_shift1 = '0;
    logic [15:0] got_q[$], got1_q[$], exp_q[$];
    int sck_rises = 0, load_rises = 0;

    always @(posedge max_sck) begin
        max_shift = {max_shift[14:0], max_din};
        sck_rises++;
    end
    always @(posedge max_load) if (!reset) begin
        got_q.push_back(max_shift);
        load_rises++;
    end
    always @(posedge max_sck1) max_shift1 = {max_shift1[14:0], max_din1};
    always @(posedge max_load1) if (!reset1) got1_q.push_back(max_shift1);

    // Pin-timing watcher for the CLK_DIV=1 instance, sampled on the falling edge.
    int ncyc = 0, last_rise = 0, frame_rises = 0, rises1 = 0;
    int din_bad = 0, period_bad = 0;
    logic prev_din1 = 1'b0, prev_sck1 = 1'b0;
    always @(negedge clock) begin
        if (reset1) begin
            frame_rises = 0;
        end else begin
            if (max_din1 !== prev_din1 && max_sck1) din_bad++;
            if (max_sck1 && !prev_sck1) begin
                if (frame_rises > 0 && (ncyc - last_rise) != 2) period_bad++;
                last_rise = ncyc;
                frame_rises++;
                rises1++;
            end
            if (max_load1) frame_rises = 0;
        end
        prev_din1 = max_din1;
        prev_sck1 = max_sck1;
        ncyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        got_q.delete();
        exp_q.delete();
        sck_rises  = 0;
        load_rises = 0;
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0C01);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic wait_ready(input int budget, output int k);
        k = 0;
        while (!frame_ready && k < budget) begin
            tick();
            k++;
        end
        if (!frame_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_sck", max_sck, 0);
        check("rst_din", max_din, 0);
        check("rst_load", max_load, 1);
        check("rst_ready", frame_ready, 0);
        check("rst_init_done", init_done, 0);
        clear_model();
        reset = 1'b0;
    endtask

    // Hands a frame over in IDLE and checks the handshake and per-frame timing.
    task automatic send_frame(input logic [15:0] data);
        int k, low;
        frame_data  = data;
        frame_valid = 1'b1;
        exp_q.push_back(data);
        tick();
        frame_valid = 1'b0;
        check("ready_drop", frame_ready, 0);
        low = max_load ? 0 : 1;
        k   = 0;
        while (!frame_ready && k < 200) begin
            tick();
            k++;
            if (!max_load) low++;
        end
        check("frame_cycles", k, 68);
        check("load_low_cycles", low, 66);
    endtask

    initial begin
        int k;
        logic [15:0] r;
        reset = 1'b1; reset1 = 1'b1;
        frame_data = '0; frame_valid = 1'b0; reinit = 1'b0;
        frame_data1 = '0; frame_valid1 = 1'b0; reinit1 = 1'b0;

        // Init sequence after reset.
        do_reset();
        push_init();
        wait_ready(400, k);
        check("init_ready_cycle", k, 341);
        check("init_done", init_done, 1);
        check("init_load_rises", load_rises, 5);
        check("init_sck_rises", sck_rises, 80);
        check_frames("init");

        // Single user frame, then random frames with random idle spacing.
        clear_model();
        send_frame(16'h0135);
        check("user_sck_rises", sck_rises, 16);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            r = 16'($urandom);
            send_frame(r);
        end
        check_frames("user");

        // Valid held across init: accepted once init is done, second frame back-to-back.
        frame_data  = 16'h0201;
        frame_valid = 1'b1;
        do_reset();
        push_init();
        wait_ready(400, k);
        check("held_ready_cycle", k, 341);
        check("held_init_done", init_done, 1);
        check("held_early_loads", load_rises, 5);
        exp_q.push_back(16'h0201);
        tick();
        frame_data = 16'h0302;
        check("held_ready_drop", frame_ready, 0);
        wait_ready(200, k);
        check("held_frame1_cycles", k, 68);
        exp_q.push_back(16'h0302);
        tick();
        frame_valid = 1'b0;
        wait_ready(200, k);
        check("held_frame2_cycles", k, 68);
        check_frames("held");

        // Reset after the 7th sck rise of a user frame.
        clear_model();
        frame_data  = 16'h0A5C;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        k = 0;
        while (sck_rises < 7 && k < 200) begin
            tick();
            k++;
        end
        check("mid_sck_reached", sck_rises, 7);
        reset = 1'b1;
        #1;
        check("mid_rst_sck", max_sck, 0);
        check("mid_rst_load", max_load, 1);
        check("mid_rst_ready", frame_ready, 0);
        check("mid_no_latch", load_rises, 0);
        do_reset();
        push_init();
        wait_ready(400, k);
        check("mid_replay_cycle", k, 341);
        check_frames("mid_replay");

        // reinit coincident with frame_valid in IDLE.
        clear_model();
        push_init();
        reinit      = 1'b1;
        frame_valid = 1'b1;
        frame_data  = 16'h0777;
        tick();
        reinit      = 1'b0;
        frame_valid = 1'b0;
        check("reinit_done_drop", init_done, 0);
        check("reinit_ready_drop", frame_ready, 0);
        wait_ready(400, k);
        check("reinit_ready_cycle", k, 341);
        check("reinit_init_done", init_done, 1);
        check_frames("reinit");

        // CLK_DIV=1 instance: init, then 0xFFFF and 0x0000.
        reset1 = 1'b0;
        k = 0;
        while (!frame_ready1 && k < 300) begin
            tick();
            k++;
        end
        check("div1_ready_cycle", k, 171);
        for (int f = 0; f < 2; f++) begin
            frame_data1  = (f == 0) ? 16'hFFFF : 16'h0000;
            frame_valid1 = 1'b1;
            tick();
            frame_valid1 = 1'b0;
            k = 0;
            while (!frame_ready1 && k < 100) begin
                tick();
                k++;
            end
            check("div1_frame_cycles", k, 34);
        end
        #6;
        check("div1_count", got1_q.size(), 7);
        if (got1_q.size() == 7) begin
            check("div1_init0", got1_q[0], 16'h0F00);
            check("div1_init4", got1_q[4], 16'h0C01);
            check("div1_ffff", got1_q[5], 16'hFFFF);
            check("div1_0000", got1_q[6], 16'h0000);
        end
        check("div1_sck_rises", rises1, 112);
        check("div1_sck_period", period_bad, 0);
        check("div1_din_stable", din_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
